// File: rtl/tinst_pkg.sv
// ---------------------------------------------------------------------------
// tinst_pkg
// Shared definitions for the tensor-instruction scheduler: instruction type
// codes, field widths, the queued instruction entry and the scheduler FSM
// state encoding.
// ---------------------------------------------------------------------------
package tinst_pkg;

    localparam int ADDR_WIDTH           = 64;
    localparam int TINST_TYPE_WIDTH     = 2;
    localparam int TMMA_PRECISION_WIDTH = 1;

    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_TMMA     = 2'd0;
    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADA = 2'd1;
    localparam logic [TINST_TYPE_WIDTH-1:0] TINST_TYPE_PRELOADC = 2'd2;

    typedef struct packed {
        logic [TINST_TYPE_WIDTH-1:0]     tinst_type;
        logic [ADDR_WIDTH-1:0]           addr0;
        logic [ADDR_WIDTH-1:0]           addr1;
        logic [TMMA_PRECISION_WIDTH-1:0] precision;
        logic                            acc;
    } tinst_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_ISSUE = 2'd2,
        S_EXEC  = 2'd3
    } sched_state_e;

    function automatic logic is_legal_type(input logic [TINST_TYPE_WIDTH-1:0] t);
        return (t == TINST_TYPE_TMMA) || (t == TINST_TYPE_PRELOADA) ||
               (t == TINST_TYPE_PRELOADC);
    endfunction

endpackage

// File: rtl/tinst_sched_fifo.sv
// ---------------------------------------------------------------------------
// tinst_sched_fifo
// Synchronous instruction FIFO with registered state. The head entry is read
// straight from storage, so a pushed entry becomes visible one cycle after the
// push edge. Flush discards everything except, optionally, the head entry.
// Ports:
//   clk, rst          clock, async active-high reset
//   push, push_data   write one entry (caller guarantees ~full)
//   pop               remove head entry (caller guarantees ~empty)
//   flush             discard queued entries; a same-cycle push is dropped
//   flush_keep_head   on flush, retain the head entry unless it is popped
//   head              current head entry
//   empty, full       occupancy flags
// ---------------------------------------------------------------------------
module tinst_sched_fifo
    import tinst_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  tinst_t push_data,
    input  logic   pop,
    input  logic   flush,
    input  logic   flush_keep_head,
    output tinst_t head,
    output logic   empty,
    output logic   full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    tinst_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            keep_one;

    // A head that is popped on the flush cycle has left for the array, so
    // nothing is kept in that case.
    assign keep_one = flush_keep_head & ~pop & (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= rd_ptr + PW'(pop) + PW'(keep_one);
            count  <= CW'(keep_one);
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/tinst_sched.sv
// ---------------------------------------------------------------------------
// tinst_sched
// In-order tensor-instruction scheduler in front of sarray_top. Queues
// PRELOADA / PRELOADC / TMMA from decode, keeps one instruction in flight and
// tracks A-buffer ping-pong occupancy so TMMA never issues without a loaded
// A tile and PRELOADA never overwrites a live one.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. Once issue_tinst_valid_o is raised it stays high with a stable
// payload until the transfer; only reset may drop it. in_tinst_ready_o does
// not depend on in_tinst_valid_i.
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_tinst_*                       decode-side instruction push (valid/ready)
//   issue_tinst_*                    head-of-queue issue to sarray_top
//   tinst_done_i                     1-cycle pulse, in-flight op finished
//   flush_i                          discard queued, not yet presented entries
//   busy_o                           queue non-empty or op in flight
//   a_buf_cnt_o                      loaded A-buffer slots
//   err_o                            1-cycle pulse on protocol/program error
//   dbg_state_o                      scheduler FSM state
//   perf_issue_cnt_o, perf_stall_cnt_o  saturating counters, only when
//                                    TINST_SCHED_PERF_EN is defined
// ---------------------------------------------------------------------------
module tinst_sched
    import tinst_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int A_BUF_NUM   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_tinst_valid_i,
    output logic                            in_tinst_ready_o,
    input  logic [TINST_TYPE_WIDTH-1:0]     in_tinst_type_i,
    input  logic [ADDR_WIDTH-1:0]           in_tinst_addr0_i,
    input  logic [ADDR_WIDTH-1:0]           in_tinst_addr1_i,
    input  logic [TMMA_PRECISION_WIDTH-1:0] in_tinst_precision_i,
    input  logic                            in_tinst_acc_i,
    output logic                            issue_tinst_valid_o,
    input  logic                            issue_tinst_ready_i,
    output logic [TINST_TYPE_WIDTH-1:0]     issue_tinst_type_o,
    output logic [ADDR_WIDTH-1:0]           issue_tinst_addr0_o,
    output logic [ADDR_WIDTH-1:0]           issue_tinst_addr1_o,
    output logic [TMMA_PRECISION_WIDTH-1:0] issue_tinst_precision_o,
    output logic                            issue_tinst_acc_o,
    input  logic                            tinst_done_i,
    input  logic                            flush_i,
    output logic                            busy_o,
    output logic [1:0]                      a_buf_cnt_o,
    output logic                            err_o,
    output logic [1:0]                      dbg_state_o
`ifdef TINST_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_issue_cnt_o,
    output logic [31:0]                     perf_stall_cnt_o
`endif
);

    localparam logic [1:0] A_MAX = 2'(A_BUF_NUM);

    tinst_t                      in_entry;
    tinst_t                      head;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        in_fire;
    logic                        in_legal;
    logic                        push;
    logic                        issue_fire;
    logic                        head_avail;
    logic                        done_ok;

    sched_state_e                state_q;
    logic                        issue_valid_q;
    logic                        inflight_q;
    logic [TINST_TYPE_WIDTH-1:0] inflight_type_q;
    logic [1:0]                  a_cnt_q;
    logic [1:0]                  a_cnt_next;
    logic                        err_q;

    function automatic logic hazard(input logic [TINST_TYPE_WIDTH-1:0] t,
                                    input logic [1:0] cnt);
        logic h;
        h = 1'b0;
        if (t == TINST_TYPE_PRELOADA) begin
            h = (cnt >= A_MAX);
        end else if (t == TINST_TYPE_TMMA) begin
            h = (cnt == 2'd0);
        end
        return h;
    endfunction

    assign in_entry = '{tinst_type: in_tinst_type_i,
                        addr0:      in_tinst_addr0_i,
                        addr1:      in_tinst_addr1_i,
                        precision:  in_tinst_precision_i,
                        acc:        in_tinst_acc_i};

    assign in_tinst_ready_o = ~fifo_full;
    assign in_fire          = in_tinst_valid_i & ~fifo_full;
    assign in_legal         = is_legal_type(in_tinst_type_i);
    // Illegal types are accepted (ready stays honest) but never stored.
    assign push             = in_fire & in_legal & ~flush_i;
    assign issue_fire       = issue_valid_q & issue_tinst_ready_i;
    assign done_ok          = tinst_done_i & inflight_q;
    // In states where nothing is presented a flush empties the queue, so the
    // FSM must not act on a head that is about to disappear.
    assign head_avail       = ~fifo_empty & ~flush_i;

    tinst_sched_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .push_data      (in_entry),
        .pop            (issue_fire),
        .flush          (flush_i),
        .flush_keep_head(issue_valid_q),
        .head           (head),
        .empty          (fifo_empty),
        .full           (fifo_full)
    );

    // Occupancy after a completing op; saturates at both ends.
    always_comb begin
        a_cnt_next = a_cnt_q;
        if (done_ok) begin
            if (inflight_type_q == TINST_TYPE_PRELOADA && a_cnt_q < A_MAX) begin
                a_cnt_next = a_cnt_q + 2'd1;
            end else if (inflight_type_q == TINST_TYPE_TMMA && a_cnt_q != 2'd0) begin
                a_cnt_next = a_cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            issue_valid_q   <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_type_q <= '0;
            a_cnt_q         <= 2'd0;
            err_q           <= 1'b0;
        end else begin
            a_cnt_q <= a_cnt_next;
            err_q   <= (in_fire & ~in_legal) | (tinst_done_i & ~inflight_q);
            // Entering STALL always means nothing is in flight, so the hazard
            // can never clear by itself: flag it as a deadlock.
            case (state_q)
                S_IDLE: begin
                    if (head_avail) begin
                        if (hazard(head.tinst_type, a_cnt_q)) begin
                            state_q <= S_STALL;
                            err_q   <= 1'b1;
                        end else begin
                            state_q       <= S_ISSUE;
                            issue_valid_q <= 1'b1;
                        end
                    end
                end
                S_STALL: begin
                    if (!head_avail) begin
                        state_q <= S_IDLE;
                    end else if (!hazard(head.tinst_type, a_cnt_q)) begin
                        state_q       <= S_ISSUE;
                        issue_valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        state_q         <= S_EXEC;
                        issue_valid_q   <= 1'b0;
                        inflight_q      <= 1'b1;
                        inflight_type_q <= head.tinst_type;
                    end
                end
                S_EXEC: begin
                    if (done_ok) begin
                        inflight_q <= 1'b0;
                        if (!head_avail) begin
                            state_q <= S_IDLE;
                        end else if (hazard(head.tinst_type, a_cnt_next)) begin
                            state_q <= S_STALL;
                            err_q   <= 1'b1;
                        end else begin
                            state_q       <= S_ISSUE;
                            issue_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    issue_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef TINST_SCHED_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue_fire && perf_issue_q != 32'hFFFF_FFFF) begin
                perf_issue_q <= perf_issue_q + 32'd1;
            end
            if (state_q == S_STALL && perf_stall_q != 32'hFFFF_FFFF) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt_o = perf_issue_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

    assign issue_tinst_valid_o     = issue_valid_q;
    assign issue_tinst_type_o      = head.tinst_type;
    assign issue_tinst_addr0_o     = head.addr0;
    assign issue_tinst_addr1_o     = head.addr1;
    assign issue_tinst_precision_o = head.precision;
    assign issue_tinst_acc_o       = head.acc;
    assign busy_o                  = ~fifo_empty | inflight_q;
    assign a_buf_cnt_o             = a_cnt_q;
    assign err_o                   = err_q;
    assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_tinst_sched.sv
// ---------------------------------------------------------------------------
// tb_tinst_sched
// Directed self-checking bench for tinst_sched. Inputs change 1 time unit
// after a rising edge; outputs are observed at that same point, away from
// the active edge.
// ---------------------------------------------------------------------------
module tb_tinst_sched;
    import tinst_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            in_valid;
    logic                            in_ready;
    logic [TINST_TYPE_WIDTH-1:0]     in_type;
    logic [ADDR_WIDTH-1:0]           in_addr0;
    logic [ADDR_WIDTH-1:0]           in_addr1;
    logic [TMMA_PRECISION_WIDTH-1:0] in_prec;
    logic                            in_acc;
    logic                            iss_valid;
    logic                            iss_ready;
    logic [TINST_TYPE_WIDTH-1:0]     iss_type;
    logic [ADDR_WIDTH-1:0]           iss_addr0;
    logic [ADDR_WIDTH-1:0]           iss_addr1;
    logic [TMMA_PRECISION_WIDTH-1:0] iss_prec;
    logic                            iss_acc;
    logic                            done;
    logic                            flush;
    logic                            busy;
    logic [1:0]                      a_cnt;
    logic                            err;
    logic [1:0]                      state;

    int checks   = 0;
    int failures = 0;
    int err_pulses = 0;

    tinst_sched dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_tinst_valid_i       (in_valid),
        .in_tinst_ready_o       (in_ready),
        .in_tinst_type_i        (in_type),
        .in_tinst_addr0_i       (in_addr0),
        .in_tinst_addr1_i       (in_addr1),
        .in_tinst_precision_i   (in_prec),
        .in_tinst_acc_i         (in_acc),
        .issue_tinst_valid_o    (iss_valid),
        .issue_tinst_ready_i    (iss_ready),
        .issue_tinst_type_o     (iss_type),
        .issue_tinst_addr0_o    (iss_addr0),
        .issue_tinst_addr1_o    (iss_addr1),
        .issue_tinst_precision_o(iss_prec),
        .issue_tinst_acc_o      (iss_acc),
        .tinst_done_i           (done),
        .flush_i                (flush),
        .busy_o                 (busy),
        .a_buf_cnt_o            (a_cnt),
        .err_o                  (err),
        .dbg_state_o            (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err === 1'b1) err_pulses++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_type   = '0;
        in_addr0  = '0;
        in_addr1  = '0;
        in_prec   = '0;
        in_acc    = 1'b0;
        iss_ready = 1'b0;
        done      = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- driver ----------------
    task automatic push_tinst(input logic [1:0] t, input logic [63:0] a0,
                              input logic [63:0] a1, input logic p, input logic acc);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_ready_timeout got=%0b exp=1", in_ready);
        end
        in_valid = 1'b1;
        in_type  = t;
        in_addr0 = a0;
        in_addr1 = a1;
        in_prec  = p;
        in_acc   = acc;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_type = '0; in_addr0 = '0; in_addr1 = '0;
        in_prec = '0; in_acc = 1'b0; iss_ready = 1'b0; done = 1'b0; flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b exp=0", iss_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (a_cnt !== 2'd0) begin failures++; $display("FAIL reset_a_cnt got=%0d exp=0", a_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        checks++; if (state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IDLE); end
        checks++; if (iss_addr0 !== 64'd0 || iss_type !== 2'd0) begin failures++; $display("FAIL reset_payload addr0=%h type=%0d exp=0", iss_addr0, iss_type); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_preload_tmma();
        int e0;
        apply_reset();
        e0 = err_pulses;
        iss_ready = 1'b1;
        push_tinst(TINST_TYPE_PRELOADA, 64'hA000_0000_0000_0100, 64'hB000_0000_0000_0100, 1'b0, 1'b0);
        push_tinst(TINST_TYPE_TMMA, 64'hA000_0000_0000_0200, 64'hB000_0000_0000_0200, 1'b1, 1'b0);
        checks++; if (iss_valid !== 1'b1 || iss_type !== TINST_TYPE_PRELOADA) begin failures++; $display("FAIL basic_first_issue valid=%0b type=%0d exp valid=1 type=%0d", iss_valid, iss_type, TINST_TYPE_PRELOADA); end
        checks++; if (iss_addr0 !== 64'hA000_0000_0000_0100) begin failures++; $display("FAIL basic_first_addr0 got=%h exp=a000000000000100", iss_addr0); end
        tick();
        checks++; if (iss_valid !== 1'b0 || state !== S_EXEC) begin failures++; $display("FAIL basic_exec valid=%0b state=%0d exp valid=0 state=%0d", iss_valid, state, S_EXEC); end
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (a_cnt !== 2'd1) begin failures++; $display("FAIL basic_a_cnt_after_pa got=%0d exp=1", a_cnt); end
        checks++; if (iss_valid !== 1'b1 || iss_type !== TINST_TYPE_TMMA) begin failures++; $display("FAIL basic_second_issue valid=%0b type=%0d exp valid=1 type=%0d", iss_valid, iss_type, TINST_TYPE_TMMA); end
        checks++; if (iss_acc !== 1'b0 || iss_prec !== 1'b1 || iss_addr1 !== 64'hB000_0000_0000_0200) begin failures++; $display("FAIL basic_tmma_payload acc=%0b prec=%0b addr1=%h", iss_acc, iss_prec, iss_addr1); end
        tick();
        tick(); tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_inflight got=%0b exp=1", busy); end
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (a_cnt !== 2'd0) begin failures++; $display("FAIL basic_a_cnt_after_tmma got=%0d exp=0", a_cnt); end
        checks++; if (busy !== 1'b0 || iss_valid !== 1'b0) begin failures++; $display("FAIL basic_idle busy=%0b valid=%0b exp 0/0", busy, iss_valid); end
        checks++; if (err_pulses - e0 !== 0) begin failures++; $display("FAIL basic_no_err got=%0d exp=0", err_pulses - e0); end
        iss_ready = 1'b0;
    endtask

    task automatic test_pa_deadlock();
        int e0;
        logic seen_valid;
        apply_reset();
        e0 = err_pulses;
        iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_tinst(TINST_TYPE_PRELOADA, 64'h100 + 64'(i), 64'h200 + 64'(i), 1'b0, 1'b0);
        end
        iss_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int w;
            w = 0;
            while (iss_valid !== 1'b1 && w < 20) begin tick(); w++; end
            checks++; if (iss_valid !== 1'b1) begin failures++; $display("FAIL pa_issue_timeout idx=%0d got=%0b exp=1", k, iss_valid); end
            tick();
            done = 1'b1; tick(); done = 1'b0;
        end
        checks++; if (a_cnt !== 2'd2) begin failures++; $display("FAIL pa_a_cnt got=%0d exp=2", a_cnt); end
        checks++; if (state !== S_STALL) begin failures++; $display("FAIL pa_stall_state got=%0d exp=%0d", state, S_STALL); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL pa_err_now got=%0b exp=1", err); end
        seen_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (iss_valid !== 1'b0) seen_valid = 1'b1;
            tick();
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL pa_no_issue got=%0b exp=0", seen_valid); end
        checks++; if (err_pulses - e0 !== 1) begin failures++; $display("FAIL pa_err_pulses got=%0d exp=1", err_pulses - e0); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pa_busy got=%0b exp=1", busy); end
        // Reset mid-operation forgets the loaded slots and the queued entry.
        rst = 1'b1; #1;
        checks++; if (a_cnt !== 2'd0 || busy !== 1'b0 || state !== S_IDLE) begin failures++; $display("FAIL pa_reset_mid a_cnt=%0d busy=%0b state=%0d exp 0/0/0", a_cnt, busy, state); end
        tick(); rst = 1'b0; tick();
        iss_ready = 1'b0;
    endtask

    task automatic test_tmma_deadlock_flush();
        int e0;
        logic seen_valid;
        apply_reset();
        e0 = err_pulses;
        push_tinst(TINST_TYPE_TMMA, 64'h300, 64'h400, 1'b0, 1'b1);
        tick();
        checks++; if (state !== S_STALL || err !== 1'b1) begin failures++; $display("FAIL tmma_stall state=%0d err=%0b exp state=%0d err=1", state, err, S_STALL); end
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (iss_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL tmma_no_issue got=%0b exp=0", seen_valid); end
        checks++; if (err_pulses - e0 !== 1) begin failures++; $display("FAIL tmma_err_pulses got=%0d exp=1", err_pulses - e0); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (busy !== 1'b0 || state !== S_IDLE) begin failures++; $display("FAIL tmma_flush busy=%0b state=%0d exp 0/%0d", busy, state, S_IDLE); end
        tick(); tick();
        checks++; if (iss_valid !== 1'b0 || a_cnt !== 2'd0) begin failures++; $display("FAIL tmma_after_flush valid=%0b a_cnt=%0d exp 0/0", iss_valid, a_cnt); end
    endtask

    task automatic test_full_hold();
        apply_reset();
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_tinst(TINST_TYPE_PRELOADC, 64'hC00 + 64'(i), 64'hD00 + 64'(i), 1'b0, 1'b0);
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        in_valid = 1'b1; in_type = TINST_TYPE_PRELOADC; in_addr0 = 64'hC04; in_addr1 = 64'hD04;
        for (int c = 0; c < 10; c++) begin
            checks++; if (iss_valid !== 1'b1 || iss_addr0 !== 64'hC00 || iss_addr1 !== 64'hD00 || iss_type !== TINST_TYPE_PRELOADC) begin
                failures++; $display("FAIL full_hold cyc=%0d valid=%0b addr0=%h addr1=%h type=%0d exp 1/c00/d00/2", c, iss_valid, iss_addr0, iss_addr1, iss_type);
            end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_hold_ready cyc=%0d got=%0b exp=0", c, in_ready); end
            tick();
        end
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || iss_valid !== 1'b0) begin failures++; $display("FAIL full_after_pop ready=%0b valid=%0b exp 1/0", in_ready, iss_valid); end
        tick(); in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_pushed got=%0b exp=0", in_ready); end
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (iss_valid !== 1'b1 || iss_addr0 !== 64'hC01) begin failures++; $display("FAIL full_next_head valid=%0b addr0=%h exp 1/c01", iss_valid, iss_addr0); end
    endtask

    task automatic test_flush_keep_head();
        apply_reset();
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_tinst(TINST_TYPE_PRELOADC, 64'hE00 + 64'(i), 64'hF00 + 64'(i), 1'b0, 1'b0);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (iss_valid !== 1'b1 || iss_addr0 !== 64'hE00) begin failures++; $display("FAIL flush_head_kept valid=%0b addr0=%h exp 1/e00", iss_valid, iss_addr0); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL flush_one_left ready=%0b busy=%0b exp 1/1", in_ready, busy); end
        push_tinst(TINST_TYPE_PRELOADC, 64'hE10, 64'hF10, 1'b0, 1'b0);
        push_tinst(TINST_TYPE_PRELOADC, 64'hE11, 64'hF11, 1'b0, 1'b0);
        in_valid = 1'b1; in_type = TINST_TYPE_PRELOADC; in_addr0 = 64'hE12; in_addr1 = 64'hF12;
        flush = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_push_ready got=%0b exp=1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (iss_valid !== 1'b1 || iss_addr0 !== 64'hE00) begin failures++; $display("FAIL flush2_head valid=%0b addr0=%h exp 1/e00", iss_valid, iss_addr0); end
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (busy !== 1'b0 || iss_valid !== 1'b0 || state !== S_IDLE) begin failures++; $display("FAIL flush_push_dropped busy=%0b valid=%0b state=%0d exp 0/0/0", busy, iss_valid, state); end
        tick(); tick();
        checks++; if (iss_valid !== 1'b0) begin failures++; $display("FAIL flush_stays_idle got=%0b exp=0", iss_valid); end
    endtask

    task automatic test_illegal_and_spurious_done();
        int e0;
        apply_reset();
        e0 = err_pulses;
        iss_ready = 1'b0;
        push_tinst(TINST_TYPE_PRELOADC, 64'h500, 64'h600, 1'b0, 1'b0);
        tick();
        push_tinst(2'b11, 64'h700, 64'h800, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%0b exp=1", err); end
        checks++; if (iss_addr0 !== 64'h500) begin failures++; $display("FAIL illegal_head got=%h exp=500", iss_addr0); end
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_width got=%0b exp=0", err); end
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (busy !== 1'b0 || iss_valid !== 1'b0) begin failures++; $display("FAIL illegal_not_queued busy=%0b valid=%0b exp 0/0", busy, iss_valid); end
        done = 1'b1; tick(); done = 1'b0;
        checks++; if (err !== 1'b1 || state !== S_IDLE || a_cnt !== 2'd0) begin failures++; $display("FAIL spurious_done err=%0b state=%0d a_cnt=%0d exp 1/0/0", err, state, a_cnt); end
        tick();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL spurious_done_width got=%0b exp=0", err); end
        checks++; if (err_pulses - e0 !== 2) begin failures++; $display("FAIL illegal_err_pulses got=%0d exp=2", err_pulses - e0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_preload_tmma();
        test_pa_deadlock();
        test_tmma_deadlock_flush();
        test_full_hold();
        test_flush_keep_head();
        test_illegal_and_spurious_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
